// File: rtl/spu_fwd_scoreboard.sv
// spu_fwd_scoreboard: per-lane in-flight result tracker for the SPU issue path.
// Every issued instruction rides a shift register (one entry per lane per stage) holding its
// destination, latency, and, once delivered, its result. Source operands are resolved to the
// youngest in-flight producer or to register-file data, and issue stalls while that producer
// has no result yet. Entries leaving the last stage drive a registered register-file write.
//
// Ports:
//   clk, reset      clock; synchronous active-high reset
//   flush           kill every entry in stages 1..PIPE_DEPTH (the WB registers are untouched)
//   iss_*           per-lane issue request: valid, write enable, rt, latency
//   src_addr/rf_data  per-lane, per-source addresses and register-file read data
//   res_valid/res_data  per-lane result delivery from the execute pipes
//   opnd_data       resolved operands (combinational)
//   stall           issue blocked this cycle (combinational, all lanes)
//   wb_valid/wb_rt/wb_data  registered register-file write port per lane
//   err             sticky: unmatched result or writer reaching WB without a result
module spu_fwd_scoreboard #(
  parameter int unsigned NUM_LANES  = 2,
  parameter int unsigned PIPE_DEPTH = 7,
  parameter int unsigned NUM_SRC    = 3,
  parameter int unsigned ADDR_W     = 7,
  parameter int unsigned QW         = 128
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              flush,
  input  logic [NUM_LANES-1:0]              iss_valid,
  input  logic [NUM_LANES-1:0]              iss_wr_en,
  input  logic [NUM_LANES*ADDR_W-1:0]       iss_rt,
  input  logic [NUM_LANES*3-1:0]            iss_lat,
  input  logic [NUM_LANES*NUM_SRC*ADDR_W-1:0] src_addr,
  input  logic [NUM_LANES*NUM_SRC*QW-1:0]   rf_data,
  input  logic [NUM_LANES-1:0]              res_valid,
  input  logic [NUM_LANES*QW-1:0]           res_data,
  output logic [NUM_LANES*NUM_SRC*QW-1:0]   opnd_data,
  output logic                              stall,
  output logic [NUM_LANES-1:0]              wb_valid,
  output logic [NUM_LANES*ADDR_W-1:0]       wb_rt,
  output logic [NUM_LANES*QW-1:0]           wb_data,
  output logic                              err
);

  localparam int unsigned LatW = 3;
  localparam int unsigned Last = PIPE_DEPTH - 1;

  // Array index s holds pipeline stage s+1.
  logic              vld_q [PIPE_DEPTH][NUM_LANES];
  logic              wen_q [PIPE_DEPTH][NUM_LANES];
  logic [ADDR_W-1:0] rt_q  [PIPE_DEPTH][NUM_LANES];
  logic [LatW-1:0]   lat_q [PIPE_DEPTH][NUM_LANES];
  logic              rdy_q [PIPE_DEPTH][NUM_LANES];
  logic [QW-1:0]     dat_q [PIPE_DEPTH][NUM_LANES];

  logic [NUM_LANES-1:0]        wb_valid_q;
  logic [NUM_LANES*ADDR_W-1:0] wb_rt_q;
  logic [NUM_LANES*QW-1:0]     wb_data_q;
  logic                        err_q;

  logic [PIPE_DEPTH-1:0]       cap [NUM_LANES];
  logic [NUM_LANES-1:0]        orphan;
  logic [NUM_LANES-1:0]        wb_valid_d;
  logic [NUM_LANES-1:0]        wb_miss;
  logic [NUM_LANES*ADDR_W-1:0] wb_rt_d;
  logic [NUM_LANES*QW-1:0]     wb_data_d;
  logic                        need_stall;

  // Result capture: one-hot stage per lane whose entry is due this cycle.
  always_comb begin : p_capture
    logic [PIPE_DEPTH-1:0] hit;
    for (int l = 0; l < NUM_LANES; l++) begin
      hit = '0;
      // Scan oldest to youngest so the lowest due stage claims the result.
      for (int s = int'(PIPE_DEPTH) - 1; s >= 0; s--) begin
        if (res_valid[l] && vld_q[s][l] && (int'(lat_q[s][l]) == s + 1)) begin
          hit    = '0;
          hit[s] = 1'b1;
        end
      end
      cap[l]    = hit;
      orphan[l] = res_valid[l] && (hit == '0);
    end
  end

  // Writeback: the entry leaving the last stage, including a result captured on the way out.
  always_comb begin : p_wb
    logic leave_rdy;
    logic live;
    wb_valid_d = '0;
    wb_miss    = '0;
    wb_rt_d    = '0;
    wb_data_d  = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      leave_rdy = rdy_q[Last][l] || cap[l][Last];
      live      = !flush && vld_q[Last][l] && wen_q[Last][l];
      wb_rt_d[l*ADDR_W +: ADDR_W] = rt_q[Last][l];
      wb_data_d[l*QW +: QW]       = cap[l][Last] ? res_data[l*QW +: QW] : dat_q[Last][l];
      wb_valid_d[l] = live && leave_rdy;
      wb_miss[l]    = live && !leave_rdy;
    end
  end

  // Operand lookup and stall.
  always_comb begin : p_lookup
    logic [ADDR_W-1:0] addr;
    logic              hit;
    logic              hit_rdy;
    logic              hazard;
    logic [QW-1:0]     hit_dat;
    int                idx;
    need_stall = 1'b0;
    opnd_data  = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      for (int j = 0; j < NUM_SRC; j++) begin
        idx     = l * int'(NUM_SRC) + j;
        addr    = src_addr[idx*ADDR_W +: ADDR_W];
        hit     = 1'b0;
        hit_rdy = 1'b0;
        hit_dat = '0;
        hazard  = 1'b0;
        // Visit oldest first; every later match is a younger producer and overrides.
        for (int k = 0; k < NUM_LANES; k++) begin
          if (wb_valid_q[k] && (wb_rt_q[k*ADDR_W +: ADDR_W] == addr)) begin
            hit     = 1'b1;
            hit_rdy = 1'b1;
            hit_dat = wb_data_q[k*QW +: QW];
          end
        end
        for (int s = int'(PIPE_DEPTH) - 1; s >= 0; s--) begin
          for (int k = 0; k < NUM_LANES; k++) begin
            if (vld_q[s][k] && wen_q[s][k] && (rt_q[s][k] == addr)) begin
              hit     = 1'b1;
              hit_rdy = rdy_q[s][k];
              hit_dat = dat_q[s][k];
            end
          end
        end
        // An older lane issuing in the same cycle is the youngest producer and has no result.
        for (int k = 0; k < l; k++) begin
          if (iss_valid[k] && iss_wr_en[k] && (iss_rt[k*ADDR_W +: ADDR_W] == addr)) begin
            hazard = 1'b1;
          end
        end
        opnd_data[idx*QW +: QW] = hit ? hit_dat : rf_data[idx*QW +: QW];
        if (iss_valid[l] && ((hit && !hit_rdy) || hazard)) begin
          need_stall = 1'b1;
        end
      end
    end
  end

  assign stall = need_stall && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < PIPE_DEPTH; s++) begin
        for (int l = 0; l < NUM_LANES; l++) begin
          vld_q[s][l] <= 1'b0;
        end
      end
      wb_valid_q <= '0;
      wb_rt_q    <= '0;
      wb_data_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      for (int l = 0; l < NUM_LANES; l++) begin
        vld_q[0][l] <= iss_valid[l] && !stall && !flush;
        wen_q[0][l] <= iss_wr_en[l];
        rt_q[0][l]  <= iss_rt[l*ADDR_W +: ADDR_W];
        lat_q[0][l] <= iss_lat[l*LatW +: LatW];
        rdy_q[0][l] <= 1'b0;
        dat_q[0][l] <= '0;
        for (int s = 1; s < PIPE_DEPTH; s++) begin
          vld_q[s][l] <= vld_q[s-1][l] && !flush;
          wen_q[s][l] <= wen_q[s-1][l];
          rt_q[s][l]  <= rt_q[s-1][l];
          lat_q[s][l] <= lat_q[s-1][l];
          rdy_q[s][l] <= rdy_q[s-1][l] || cap[l][s-1];
          dat_q[s][l] <= cap[l][s-1] ? res_data[l*QW +: QW] : dat_q[s-1][l];
        end
      end
      wb_valid_q <= wb_valid_d;
      wb_rt_q    <= wb_rt_d;
      wb_data_q  <= wb_data_d;
      if ((|orphan) || (|wb_miss)) begin
        err_q <= 1'b1;
      end
    end
  end

  assign wb_valid = wb_valid_q;
  assign wb_rt    = wb_rt_q;
  assign wb_data  = wb_data_q;
  assign err      = err_q;

endmodule

// File: tb/tb_spu_fwd_scoreboard.sv
// Bench for spu_fwd_scoreboard: directed scenarios followed by random traffic, all checked
// against an instruction-list reference model (producers ordered by issue cycle and lane).
module tb_spu_fwd_scoreboard;
  localparam int NL = 2;
  localparam int PD = 7;
  localparam int NS = 3;
  localparam int AW = 7;
  localparam int QW = 128;
  localparam logic [QW-1:0] A5 = {16{8'hA5}};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                reset, flush;
  logic [NL-1:0]       iss_valid, iss_wr_en, res_valid, wb_valid;
  logic [NL*AW-1:0]    iss_rt, wb_rt;
  logic [NL*3-1:0]     iss_lat;
  logic [NL*NS*AW-1:0] src_addr;
  logic [NL*NS*QW-1:0] rf_data, opnd_data;
  logic [NL*QW-1:0]    res_data, wb_data;
  logic                stall, err;

  spu_fwd_scoreboard dut (
    .clk(clk), .reset(reset), .flush(flush), .iss_valid(iss_valid), .iss_wr_en(iss_wr_en),
    .iss_rt(iss_rt), .iss_lat(iss_lat), .src_addr(src_addr), .rf_data(rf_data),
    .res_valid(res_valid), .res_data(res_data), .opnd_data(opnd_data), .stall(stall),
    .wb_valid(wb_valid), .wb_rt(wb_rt), .wb_data(wb_data), .err(err)
  );

  typedef struct {
    int          lane;
    bit          wen;
    logic [AW-1:0] rt;
    int          lat;
    int          iss;
    bit          rdy;
    logic [QW-1:0] data;
  } rec_t;

  rec_t          recs[$];
  int            cyc = 0;
  bit            m_err = 1'b0;
  bit            m_stall = 1'b0;
  bit            m_wb_zero = 1'b0;
  bit            m_wb_v [NL];
  logic [AW-1:0] m_wb_rt [NL];
  logic [QW-1:0] m_wb_d [NL];
  int            checks = 0;
  int            errors = 0;

  task automatic chk(input string tag, input logic [QW-1:0] got, input logic [QW-1:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic idle();
    iss_valid = '0; iss_wr_en = '0; iss_rt = '0; iss_lat = {NL{3'd1}};
    src_addr = '0; rf_data = '0; res_valid = '0; res_data = '0; flush = 1'b0;
  endtask

  task automatic issue(input int l, input bit wen, input int rt, input int lat);
    iss_valid[l] = 1'b1;
    iss_wr_en[l] = wen;
    iss_rt[l*AW +: AW] = AW'(rt);
    iss_lat[l*3 +: 3] = 3'(lat);
  endtask

  task automatic src(input int l, input int j, input int a, input logic [QW-1:0] rf);
    src_addr[(l*NS+j)*AW +: AW] = AW'(a);
    rf_data[(l*NS+j)*QW +: QW] = rf;
  endtask

  task automatic res(input int l, input logic [QW-1:0] d);
    res_valid[l] = 1'b1;
    res_data[l*QW +: QW] = d;
  endtask

  // Combinational outputs: youngest producer in program order, or register-file data.
  task automatic model_comb();
    int idx, st;
    logic [AW-1:0] a;
    bit found, rdy;
    longint best, key;
    logic [QW-1:0] d;
    m_stall = 1'b0;
    for (int l = 0; l < NL; l++) begin
      for (int j = 0; j < NS; j++) begin
        idx = l*NS + j;
        a = src_addr[idx*AW +: AW];
        found = 1'b0; rdy = 1'b0; best = -1; d = '0;
        foreach (recs[i]) begin
          st = cyc - recs[i].iss;
          if (recs[i].wen && recs[i].rt == a && st >= 1 && st <= PD + 1) begin
            key = longint'(recs[i].iss) * NL + recs[i].lane;
            if (key > best) begin
              best = key; found = 1'b1; rdy = recs[i].rdy; d = recs[i].data;
            end
          end
        end
        for (int k = 0; k < l; k++) begin
          if (iss_valid[k] && iss_wr_en[k] && iss_rt[k*AW +: AW] == a) begin
            found = 1'b1; rdy = 1'b0;
          end
        end
        if (iss_valid[l] && found && !rdy) m_stall = 1'b1;
        if (!found) chk($sformatf("opnd_rf l%0d s%0d", l, j), opnd_data[idx*QW +: QW],
                        rf_data[idx*QW +: QW]);
        else if (rdy) chk($sformatf("opnd_fwd l%0d s%0d", l, j), opnd_data[idx*QW +: QW], d);
      end
    end
    if (reset) m_stall = 1'b0;
    chk("stall", stall, m_stall);
  endtask

  // Clock edge: results, flush, retirement, issue, then the expected WB contents.
  task automatic model_edge();
    int st, best;
    rec_t keep[$];
    rec_t n;
    if (reset) begin
      recs.delete();
      m_err = 1'b0;
      cyc++;
      for (int l = 0; l < NL; l++) m_wb_v[l] = 1'b0;
      m_wb_zero = 1'b1;
      return;
    end
    m_wb_zero = 1'b0;
    for (int l = 0; l < NL; l++) begin
      if (res_valid[l]) begin
        best = -1;
        foreach (recs[i]) begin
          st = cyc - recs[i].iss;
          if (recs[i].lane == l && st >= 1 && st <= PD && st == recs[i].lat &&
              (best < 0 || recs[i].iss > recs[best].iss)) best = i;
        end
        if (best < 0) m_err = 1'b1;
        else begin
          recs[best].rdy = 1'b1;
          recs[best].data = res_data[l*QW +: QW];
        end
      end
    end
    if (flush) recs.delete();
    else begin
      foreach (recs[i]) begin
        st = cyc - recs[i].iss;
        if (st < PD) keep.push_back(recs[i]);
        else if (st == PD && recs[i].wen) begin
          if (recs[i].rdy) keep.push_back(recs[i]);
          else m_err = 1'b1;
        end
      end
      recs = keep;
      if (!m_stall) begin
        for (int l = 0; l < NL; l++) begin
          if (iss_valid[l]) begin
            n.lane = l; n.wen = iss_wr_en[l]; n.rt = iss_rt[l*AW +: AW];
            n.lat = int'(iss_lat[l*3 +: 3]); n.iss = cyc; n.rdy = 1'b0; n.data = '0;
            recs.push_back(n);
          end
        end
      end
    end
    cyc++;
    for (int l = 0; l < NL; l++) begin
      m_wb_v[l] = 1'b0;
      foreach (recs[i]) begin
        if (recs[i].lane == l && cyc - recs[i].iss == PD + 1) begin
          m_wb_v[l] = 1'b1; m_wb_rt[l] = recs[i].rt; m_wb_d[l] = recs[i].data;
        end
      end
    end
  endtask

  task automatic check_regs();
    for (int l = 0; l < NL; l++) begin
      chk($sformatf("wb_valid l%0d", l), wb_valid[l], m_wb_v[l]);
      if (m_wb_v[l]) begin
        chk($sformatf("wb_rt l%0d", l), wb_rt[l*AW +: AW], m_wb_rt[l]);
        chk($sformatf("wb_data l%0d", l), wb_data[l*QW +: QW], m_wb_d[l]);
      end else if (m_wb_zero) begin
        chk($sformatf("wb_rt rst l%0d", l), wb_rt[l*AW +: AW], '0);
        chk($sformatf("wb_data rst l%0d", l), wb_data[l*QW +: QW], '0);
      end
    end
    chk("err", err, m_err);
  endtask

  // One cycle: inputs already driven; check outputs, clock, check registers.
  task automatic step();
    #2;
    model_comb();
    @(posedge clk);
    model_edge();
    #1;
    check_regs();
  endtask

  int st_r;
  bit due;

  initial begin
    idle();
    reset = 1'b1;
    #1;
    step();
    step();
    reset = 1'b0;
    #1;
    chk("reset wb_valid", wb_valid, '0);
    chk("reset err", err, '0);
    chk("reset stall", stall, '0);

    // Forwarding with stall, then writeback and forwarding from WB.
    idle(); issue(0, 1, 5, 2); step();
    idle(); issue(1, 0, 40, 1); src(1, 0, 5, 128'h1111); #1;
    chk("s1 stall t0+1", stall, 1'b1); step();
    idle(); issue(1, 0, 40, 1); src(1, 0, 5, 128'h1111); res(0, A5); #1;
    chk("s1 stall t0+2", stall, 1'b1); step();
    idle(); issue(1, 0, 40, 1); src(1, 0, 5, 128'h1111); #1;
    chk("s1 stall t0+3", stall, 1'b0);
    chk("s1 opnd t0+3", opnd_data[3*QW +: QW], A5); step();
    idle(); repeat (4) step();
    idle(); src(1, 0, 5, 128'hBEEF); #1;
    chk("s1 wb_valid", wb_valid[0], 1'b1);
    chk("s1 wb_rt", wb_rt[AW-1:0], 5);
    chk("s1 wb_data", wb_data[QW-1:0], A5);
    chk("s3 wb fwd", opnd_data[3*QW +: QW], A5); step();

    // Same-rt producers: higher lane wins; lower stage wins.
    idle(); issue(0, 1, 9, 1); issue(1, 1, 9, 1); step();
    idle(); res(0, 128'h1); res(1, 128'h2); step();
    idle(); issue(0, 0, 41, 1); src(0, 0, 9, 128'h5555); #1;
    chk("s2 lane prio stall", stall, 1'b0);
    chk("s2 lane prio", opnd_data[0 +: QW], 128'h2); step();
    idle(); issue(0, 1, 9, 1); step();
    idle(); res(0, 128'h7); step();
    idle(); issue(0, 1, 9, 1); step();
    idle(); res(0, 128'h3); step();
    idle(); issue(0, 0, 42, 1); src(0, 1, 100, 128'hDEAD); src(1, 2, 9, 128'h5555); #1;
    chk("s2 stage prio", opnd_data[5*QW +: QW], 128'h3);
    chk("s3 rf opnd", opnd_data[1*QW +: QW], 128'hDEAD);
    chk("s3 rf stall", stall, 1'b0); step();

    // Flush: three in flight are killed, the one already in WB still writes.
    idle(); repeat (8) step();
    idle(); issue(1, 1, 20, 1); step();
    idle(); res(1, 128'h20); step();
    idle(); repeat (3) step();
    idle(); issue(0, 1, 21, 1); step();
    idle(); res(0, 128'h21); issue(0, 1, 22, 1); step();
    idle(); res(0, 128'h22); issue(0, 1, 23, 1); step();
    idle(); res(0, 128'h23); flush = 1'b1; #1;
    chk("s4 wb kept", wb_valid, 2'b10);
    chk("s4 wb kept rt", wb_rt[AW +: AW], 20); step();
    idle();
    for (int i = 0; i < 9; i++) begin
      #1; chk("s4 flushed wb", wb_valid, '0); step();
    end

    // Sticky err and reset mid-flight.
    idle(); res(1, 128'h99); step();
    chk("s5 err set", err, 1'b1);
    idle(); repeat (3) step();
    chk("s5 err sticky", err, 1'b1);
    idle(); issue(0, 1, 30, 3); step();
    idle(); issue(1, 1, 31, 2); step();
    idle(); reset = 1'b1; issue(0, 1, 32, 1); issue(1, 0, 43, 1); src(1, 0, 32, 128'h1); #1;
    chk("s5 stall in reset", stall, 1'b0); step();
    reset = 1'b0;
    chk("s5 wb after reset", wb_valid, '0);
    chk("s5 err after reset", err, 1'b0);
    idle(); repeat (9) step();

    // Random traffic.
    for (int c = 0; c < 600; c++) begin
      idle();
      reset = ($urandom_range(0, 79) == 0);
      flush = ($urandom_range(0, 29) == 0);
      for (int l = 0; l < NL; l++) begin
        if ($urandom_range(0, 2) != 0)
          issue(l, $urandom_range(0, 3) != 0, int'($urandom_range(0, 7)),
                int'($urandom_range(1, 7)));
      end
      for (int i = 0; i < NL*NS; i++) begin
        src_addr[i*AW +: AW] = AW'($urandom_range(0, 9));
        rf_data[i*QW +: QW] = {$urandom, $urandom, $urandom, $urandom};
      end
      for (int l = 0; l < NL; l++) begin
        due = 1'b0;
        foreach (recs[i]) begin
          st_r = cyc - recs[i].iss;
          if (recs[i].lane == l && st_r >= 1 && st_r <= PD && st_r == recs[i].lat) due = 1'b1;
        end
        if ((due && $urandom_range(0, 9) != 0) || $urandom_range(0, 49) == 0)
          res(l, {$urandom, $urandom, $urandom, $urandom});
      end
      step();
    end
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
